bus_arbiter: RTL

Parametrised N-core shared-RAM bus arbiter, the successor to the two-core `bus`. It accepts level requests from `N_CORES` cores and grants the RAM port to one core at a time in round-robin order. It sequences each access through a fixed-latency RAM and returns read data with a one-cycle done pulse. It sits between the core array and the single-port data RAM.

---
 rtl/bus_arbiter_if.sv | 43 ++++
 rtl/bus_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: core-array and RAM-side signals of the shared-RAM arbiter.
//   master modport : arbiter side (drives grant/done/read data and the RAM port)
//   slave modport  : core array / RAM side
//   core_lock exists only when BUS_ARBITER_LOCK_EN is defined.
interface bus_arbiter_if #(
    parameter int unsigned N_CORES = 2,
    parameter int unsigned DW      = 8,
    parameter int unsigned AW      = 8
);
    logic [N_CORES-1:0]    core_request;
    logic [N_CORES-1:0]    core_rw;
    logic [N_CORES*AW-1:0] core_address;
    logic [N_CORES*DW-1:0] core_data_in;
    logic [N_CORES-1:0]    core_grant;
    logic [N_CORES-1:0]    core_done;
    logic [DW-1:0]         core_data_out;
    logic [AW-1:0]         RAM_address;
    logic [DW-1:0]         RAM_data_in;
    logic [DW-1:0]         RAM_data_out;
    logic                  RAM_en;
    logic                  rw;
`ifdef BUS_ARBITER_LOCK_EN
    logic [N_CORES-1:0]    core_lock;
`endif

    modport master (
`ifdef BUS_ARBITER_LOCK_EN
        input  core_lock,
`endif
        input  core_request, core_rw, core_address, core_data_in, RAM_data_out,
        output core_grant, core_done, core_data_out,
        output RAM_address, RAM_data_in, RAM_en, rw
    );

    modport slave (
`ifdef BUS_ARBITER_LOCK_EN
        output core_lock,
`endif
        output core_request, core_rw, core_address, core_data_in, RAM_data_out,
        input  core_grant, core_done, core_data_out,
        input  RAM_address, RAM_data_in, RAM_en, rw
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin N-core arbiter in front of a single-port,
// fixed-latency RAM. One access per grant: IDLE -> ACCESS -> WAIT x RAM_LATENCY
// -> DONE. Read data is returned on the shared core_data_out with a one-cycle
// core_done pulse on the winner.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : bus_arbiter_if.master (core requests/grants/done, RAM port)
// Option: BUS_ARBITER_LOCK_EN adds core_lock; a locked winner re-enters ACCESS
// straight from DONE without re-arbitration (read-modify-write atomicity).
module bus_arbiter #(
    parameter int unsigned N_CORES     = 2,
    parameter int unsigned DW          = 8,
    parameter int unsigned AW          = 8,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.master bus
);
    localparam int unsigned IW = $clog2(N_CORES);
    localparam int unsigned CW = $clog2(RAM_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      winner_q, winner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_CORES-1:0] grant_q, grant_d;
    logic [N_CORES-1:0] done_q, done_d;
    logic [DW-1:0]      dout_q, dout_d;
    // RAM-side registers double as the latched request; they hold outside ACCESS.
    logic [AW-1:0]      ram_addr_q, ram_addr_d;
    logic [DW-1:0]      ram_wdata_q, ram_wdata_d;
    logic               rw_q, rw_d;
    logic               ram_en_q, ram_en_d;

    logic               pick_vld;
    logic [IW-1:0]      pick;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      sel;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic               sel_rw;
    logic               load;

    // Round-robin pick: first requester searching upward from last+1.
    always_comb begin
        pick_vld = 1'b0;
        pick     = last_q;
        idx      = last_q;
        for (int unsigned k = 1; k <= N_CORES; k++) begin
            idx = IW'((32'(last_q) + k) % N_CORES);
            if (!pick_vld && bus.core_request[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    // Source of the fields to latch: new winner in IDLE, current winner on a locked DONE.
    always_comb begin
        sel       = (state_q == S_DONE) ? winner_q : pick;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rw    = 1'b0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (IW'(i) == sel) begin
                sel_addr  = bus.core_address[i*AW +: AW];
                sel_wdata = bus.core_data_in[i*DW +: DW];
                sel_rw    = bus.core_rw[i];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        winner_d    = winner_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        done_d      = '0;
        dout_d      = dout_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rw_d        = rw_q;
        ram_en_d    = 1'b0;
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    winner_d       = pick;
                    last_d         = pick;
                    grant_d        = '0;
                    grant_d[pick]  = 1'b1;
                    load           = 1'b1;
                    state_d        = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d   = CW'(RAM_LATENCY);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    if (rw_q) begin
                        dout_d = bus.RAM_data_out;
                    end
                    done_d[winner_q] = 1'b1;
                    state_d          = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                grant_d = '0;
                state_d = S_IDLE;
`ifdef BUS_ARBITER_LOCK_EN
                if (bus.core_lock[winner_q] && bus.core_request[winner_q]) begin
                    grant_d = grant_q;
                    load    = 1'b1;
                    state_d = S_ACCESS;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            ram_addr_d  = sel_addr;
            ram_wdata_d = sel_wdata;
            rw_d        = sel_rw;
            ram_en_d    = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            last_q      <= IW'(N_CORES - 1);
            winner_q    <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            dout_q      <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rw_q        <= 1'b0;
            ram_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            winner_q    <= winner_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            dout_q      <= dout_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rw_q        <= rw_d;
            ram_en_q    <= ram_en_d;
        end
    end

    assign bus.core_grant    = grant_q;
    assign bus.core_done     = done_q;
    assign bus.core_data_out = dout_q;
    assign bus.RAM_address   = ram_addr_q;
    assign bus.RAM_data_in   = ram_wdata_q;
    assign bus.RAM_en        = ram_en_q;
    assign bus.rw            = rw_q;
endmodule
